// File: rtl/npc_pred.sv
// npc_pred: fetch PC register with next-PC prediction and mispredict redirect.
// Optional BTB with 2-bit saturating counters is built when NPC_BTB_EN is defined.
module npc_pred #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            pc_write,
  input  logic            ex_valid,
  input  logic            ex_is_br,
  input  logic            ex_is_jmp,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush
);

  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  // ex_valid is a pure qualifier: the resolve slot has no backpressure and is
  // consumed in every cycle it is valid, regardless of pc_write.
  logic            is_cti;
  logic            actual;
  logic            redirect;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] ex_pc_plus4;
  logic [XLEN-1:0] pc_next;

  assign is_cti      = ex_is_br | ex_is_jmp;
  assign actual      = ex_is_jmp | (ex_is_br & ex_taken);
  assign redirect    = ex_valid & is_cti &
                       ((actual != ex_pred_taken) |
                        (actual & (ex_target != ex_pred_target)));
  assign flush       = redirect;
  assign pc_plus4    = pc + FOUR;
  assign ex_pc_plus4 = ex_pc + FOUR;

  // Redirect wins over a stall so the squash is never lost.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = actual ? ex_target : ex_pc_plus4;
    end else if (pc_write) begin
      pc_next = pred_target;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

`ifdef NPC_BTB_EN
  localparam int TAGW = XLEN - IDXW - 2;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [IDXW-1:0] rd_idx;
  logic [IDXW-1:0] wr_idx;
  logic [TAGW-1:0] rd_tag;
  logic [TAGW-1:0] wr_tag;
  logic            rd_hit;
  logic            wr_hit;
  logic            upd;

  assign rd_idx = pc[IDXW+1:2];
  assign rd_tag = pc[XLEN-1:IDXW+2];
  assign wr_idx = ex_pc[IDXW+1:2];
  assign wr_tag = ex_pc[XLEN-1:IDXW+2];

  // Lookup reads the array before the edge, so a same-index update this cycle
  // only becomes visible to the following fetch.
  assign rd_hit      = btb_valid[rd_idx] & (btb_tag[rd_idx] == rd_tag);
  assign pred_taken  = rd_hit & btb_ctr[rd_idx][1];
  assign pred_target = pred_taken ? btb_target[rd_idx] : pc_plus4;

  assign upd    = ex_valid & is_cti;
  assign wr_hit = btb_valid[wr_idx] & (btb_tag[wr_idx] == wr_tag);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (wr_hit) begin
        if (actual) begin
          if (btb_ctr[wr_idx] != 2'b11) begin
            btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'd1;
          end
          btb_target[wr_idx] <= ex_target;
        end else if (btb_ctr[wr_idx] != 2'b00) begin
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'd1;
        end
      end else if (actual) begin
        // Jumps are always taken, so they start strongly taken.
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= ex_target;
        btb_ctr[wr_idx]    <= ex_is_jmp ? 2'b11 : 2'b10;
      end
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

endmodule

// File: tb/tb_npc_pred.sv
// tb_npc_pred: table vectors, directed corner sequences and random stimulus
// checked against an address-arithmetic model of the predictor.
`timescale 1ns/1ps
module tb_npc_pred;

  localparam int          XLEN   = 32;
  localparam int          N      = 16;
  localparam logic [31:0] RST_PC = 32'h100;
`ifdef NPC_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic            clk;
  logic            rstn;
  logic            pc_write;
  logic            ex_valid;
  logic            ex_is_br;
  logic            ex_is_jmp;
  logic            ex_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            flush;

  npc_pred #(.XLEN(XLEN), .BTB_ENTRIES(N), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn), .pc_write(pc_write), .ex_valid(ex_valid),
    .ex_is_br(ex_is_br), .ex_is_jmp(ex_is_jmp), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .pc(pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .flush(flush)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // scoreboard
  int total;
  int bad;
  logic [XLEN-1:0] exp_q[$];
  logic            last_flush;
  logic            last_pt;
  logic [31:0]     last_ptgt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: BTB as plain arrays indexed by word address modulo N
  bit          m_valid[N];
  logic [31:0] m_tag[N];
  logic [31:0] m_tgt[N];
  int          m_ctr[N];
  logic [31:0] m_pc;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 32'(N));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / 32'(4 * N);
  endfunction

  function automatic void m_predict(input logic [31:0] a, output bit t, output logic [31:0] tg);
    int i;
    i  = idx_of(a);
    t  = BTB_EN && m_valid[i] && (m_tag[i] == tag_of(a)) && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : a + 32'd4;
  endfunction

  function automatic bit m_actual();
    return ex_is_jmp || (ex_is_br && ex_taken);
  endfunction

  function automatic bit m_redirect();
    if (!ex_valid || !(ex_is_br || ex_is_jmp)) return 1'b0;
    if (m_actual() != ex_pred_taken) return 1'b1;
    return m_actual() && (ex_target != ex_pred_target);
  endfunction

  function automatic void m_reset();
    m_pc = RST_PC;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void m_advance();
    bit          t;
    bit          act;
    int          i;
    logic [31:0] tg;
    logic [31:0] nxt;
    m_predict(m_pc, t, tg);
    act = m_actual();
    if (m_redirect()) nxt = act ? ex_target : ex_pc + 32'd4;
    else if (pc_write) nxt = tg;
    else nxt = m_pc;
    if (BTB_EN && ex_valid && (ex_is_br || ex_is_jmp)) begin
      i = idx_of(ex_pc);
      if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
        m_ctr[i] = act ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                       : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (act) m_tgt[i] = ex_target;
      end else if (act) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(ex_pc);
        m_tgt[i]   = ex_target;
        m_ctr[i]   = ex_is_jmp ? 3 : 2;
      end
    end
    m_pc = nxt;
    exp_q.push_back(nxt);
  endfunction

  // driver tasks: callers set inputs at posedge+1, cycle() ends at posedge+1
  task automatic set_idle(input bit pw);
    pc_write = pw; ex_valid = 1'b0; ex_is_br = 1'b0; ex_is_jmp = 1'b0;
    ex_taken = 1'b0; ex_pc = '0; ex_target = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic cycle();
    bit          t;
    logic [31:0] tg;
    #1;
    m_predict(m_pc, t, tg);
    last_flush = flush;
    last_pt    = pred_taken;
    last_ptgt  = pred_target;
    check("pred_taken", 32'(pred_taken), 32'(t));
    check("pred_target", pred_target, tg);
    check("flush", 32'(flush), 32'(m_redirect()));
    m_advance();
    @(posedge clk);
    #1;
    check("pc", pc, exp_q.pop_front());
  endtask

  task automatic resolve(input bit br, input bit jmp, input bit tk, input logic [31:0] epc,
                         input logic [31:0] etgt, input bit ppt, input logic [31:0] pptg,
                         input bit pw);
    pc_write = pw; ex_valid = 1'b1; ex_is_br = br; ex_is_jmp = jmp; ex_taken = tk;
    ex_pc = epc; ex_target = etgt; ex_pred_taken = ppt; ex_pred_target = pptg;
    cycle();
  endtask

  task automatic idle(input bit pw);
    set_idle(pw);
    cycle();
  endtask

  // a mispredicted not-taken branch at a-4 moves fetch to a without touching the BTB
  task automatic goto_pc(input logic [31:0] a);
    resolve(1'b1, 1'b0, 1'b0, a - 32'd4, 32'h0, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    resolve_inputs_for_reset();
    #1 rstn = 1'b0;
    #1;
    check("rst_pc_async", pc, RST_PC);
    check("rst_pred_taken", 32'(pred_taken), 32'h0);
    check("rst_pred_target", pred_target, RST_PC + 32'd4);
    check("rst_flush_follows_inputs", 32'(flush), 32'h1);
    @(posedge clk);
    #1;
    check("rst_pc_hold", pc, RST_PC);
    set_idle(1'b1);
    rstn = 1'b1;
    m_reset();
    exp_q.delete();
  endtask

  // a taken branch that would allocate if the edge were not held in reset
  task automatic resolve_inputs_for_reset();
    pc_write = 1'b1; ex_valid = 1'b1; ex_is_br = 1'b1; ex_is_jmp = 1'b0; ex_taken = 1'b1;
    ex_pc = 32'h40; ex_target = 32'h20; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
  endtask

  typedef struct {
    bit          pw, v, br, jmp, tk;
    logic [31:0] epc, etgt;
    bit          ppt;
    logic [31:0] pptg;
    bit          exp_flush;
    logic [31:0] exp_ptgt;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(input bit pw, v, br, jmp, tk, input logic [31:0] epc, etgt,
                              input bit ppt, input logic [31:0] pptg, input bit ef,
                              input logic [31:0] ept, epcn);
    vec_t r;
    r.pw = pw; r.v = v; r.br = br; r.jmp = jmp; r.tk = tk; r.epc = epc; r.etgt = etgt;
    r.ppt = ppt; r.pptg = pptg; r.exp_flush = ef; r.exp_ptgt = ept; r.exp_pc = epcn;
    return r;
  endfunction

  vec_t tbl[15];

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b1;
    set_idle(1'b1);
    m_reset();

    tbl[0]  = mk(1,0,0,0,0, 32'h0,        32'h0,        0, 32'h0,   0, 32'h104,      32'h104);
    tbl[1]  = mk(0,0,0,0,0, 32'h0,        32'h0,        0, 32'h0,   0, 32'h108,      32'h104);
    tbl[2]  = mk(1,1,1,0,1, 32'h8000_0040, 32'h300,     0, 32'h0,   1, 32'h108,      32'h300);
    tbl[3]  = mk(1,1,1,0,0, 32'h8000_0080, 32'h0,       1, 32'h500, 1, 32'h304,      32'h8000_0084);
    tbl[4]  = mk(1,1,0,1,1, 32'h8000_0100, 32'h600,     1, 32'h700, 1, 32'h8000_0088, 32'h600);
    tbl[5]  = mk(1,1,0,1,1, 32'h8000_0200, 32'h800,     1, 32'h800, 0, 32'h604,      32'h604);
    tbl[6]  = mk(0,1,1,0,1, 32'h8000_0300, 32'h900,     0, 32'h0,   1, 32'h608,      32'h900);
    tbl[7]  = mk(1,1,0,0,1, 32'h8000_0340, 32'h1000,    1, 32'h0,   0, 32'h904,      32'h904);
    tbl[8]  = mk(1,0,1,0,1, 32'h8000_0380, 32'h1000,    0, 32'h0,   0, 32'h908,      32'h908);
    tbl[9]  = mk(1,1,1,0,1, 32'h8000_0400, 32'hA00,     1, 32'hA00, 0, 32'h90C,      32'h90C);
    tbl[10] = mk(1,1,1,0,0, 32'h8000_0400, 32'hA00,     0, 32'h0,   0, 32'h910,      32'h910);
    tbl[11] = mk(1,1,1,0,1, 32'h8000_0400, 32'hB00,     1, 32'hA04, 1, 32'h914,      32'hB00);
    tbl[12] = mk(1,1,0,1,1, 32'h8000_0500, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'hB04,      32'hFFFF_FFFC);
    tbl[13] = mk(1,0,0,0,0, 32'h0,        32'h0,        0, 32'h0,   0, 32'h0,        32'h0);
    tbl[14] = mk(1,1,1,0,0, 32'hFFFF_FFFC, 32'h0,       1, 32'h10,  1, 32'h4,        32'h0);

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      pc_write = tbl[i].pw; ex_valid = tbl[i].v; ex_is_br = tbl[i].br; ex_is_jmp = tbl[i].jmp;
      ex_taken = tbl[i].tk; ex_pc = tbl[i].epc; ex_target = tbl[i].etgt;
      ex_pred_taken = tbl[i].ppt; ex_pred_target = tbl[i].pptg;
      #1;
      check($sformatf("tbl%0d_flush", i), 32'(flush), 32'(tbl[i].exp_flush));
      check($sformatf("tbl%0d_pred_target", i), pred_target, tbl[i].exp_ptgt);
      cycle();
      check($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
    end

    // stall holds pc, then releases by one word
    resolve(1'b0, 1'b1, 1'b1, 32'h8000_0600, 32'h200, 1'b0, 32'h0, 1'b1);
    check("stall_setup_pc", pc, 32'h200);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("stall_pc", pc, 32'h200);
    end
    idle(1'b1);
    check("stall_release_pc", pc, 32'h204);

`ifdef NPC_BTB_EN
    do_reset();
    // learn a backward loop branch
    resolve(1'b1, 1'b0, 1'b1, 32'h40, 32'h20, 1'b0, 32'h0, 1'b1);
    check("learn_flush", 32'(last_flush), 32'h1);
    check("learn_pc", pc, 32'h20);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("learn_fetch_pc", pc, 32'h40);
    #1;
    check("learn_pred_taken", 32'(pred_taken), 32'h1);
    check("learn_pred_target", pred_target, 32'h20);
    // same-cycle lookup sees pre-update entry; mispredict goes to fall-through
    resolve(1'b1, 1'b0, 1'b0, 32'h40, 32'h20, 1'b1, 32'h20, 1'b1);
    check("sat_same_cycle_pred", 32'(last_pt), 32'h1);
    check("sat_redirect_pc", pc, 32'h44);
    goto_pc(32'h40);
    #1;
    check("sat_ctr01_pred", 32'(pred_taken), 32'h0);
    check("sat_ctr01_target", pred_target, 32'h44);
    resolve(1'b1, 1'b0, 1'b0, 32'h40, 32'h20, 1'b0, 32'h0, 1'b1);
    check("sat_nt2_flush", 32'(last_flush), 32'h0);
    resolve(1'b1, 1'b0, 1'b0, 32'h40, 32'h20, 1'b0, 32'h0, 1'b1);
    goto_pc(32'h40);
    #1;
    check("sat_ctr00_pred", 32'(pred_taken), 32'h0);
    resolve(1'b1, 1'b0, 1'b1, 32'h40, 32'h20, 1'b0, 32'h0, 1'b1);
    goto_pc(32'h40);
    #1;
    check("sat_up_to01_pred", 32'(pred_taken), 32'h0);
    resolve(1'b1, 1'b0, 1'b1, 32'h40, 32'h20, 1'b0, 32'h0, 1'b1);
    goto_pc(32'h40);
    #1;
    check("sat_up_to10_pred", 32'(pred_taken), 32'h1);
    // aliasing: same index, different tag
    goto_pc(32'h440);
    #1;
    check("alias_miss_pred", 32'(pred_taken), 32'h0);
    resolve(1'b1, 1'b0, 1'b1, 32'h440, 32'h80, 1'b0, 32'h0, 1'b1);
    check("alias_alloc_same_cycle", 32'(last_pt), 32'h0);
    check("alias_alloc_pc", pc, 32'h80);
    goto_pc(32'h40);
    #1;
    check("alias_evicted_pred", 32'(pred_taken), 32'h0);
    goto_pc(32'h440);
    #1;
    check("alias_hit_pred", 32'(pred_taken), 32'h1);
    check("alias_hit_target", pred_target, 32'h80);
`endif

    // random stimulus against the model, with occasional resets
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit          mt;
      logic [31:0] mtg;
      int          kind;
      if (n % 130 == 129) do_reset();
      kind           = $urandom_range(0, 4);
      pc_write       = ($urandom_range(0, 3) != 0);
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_is_br       = (kind == 1 || kind == 2 || kind == 4);
      ex_is_jmp      = (kind == 3 || kind == 4);
      ex_taken       = $urandom_range(0, 1) != 0;
      ex_pc          = ($urandom_range(0, 1) != 0) ? m_pc : 32'($urandom_range(0, 511) * 4);
      ex_target      = 32'($urandom_range(0, 511) * 4);
      m_predict(ex_pc, mt, mtg);
      if ($urandom_range(0, 1) != 0) begin
        ex_pred_taken  = mt;
        ex_pred_target = mtg;
      end else begin
        ex_pred_taken  = $urandom_range(0, 1) != 0;
        ex_pred_target = ($urandom_range(0, 1) != 0) ? ex_target : 32'($urandom_range(0, 511) * 4);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npc_pred.md
NPC_PRED -- requirements
Module: npc_pred

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16, BTB depth; power of two, >=2; IDXW = log2(BTB_ENTRIES).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-004 SHALL have ports (clock and reset first), one per line:
  clk  input  1  single clock; all state updates on rising edge.
  rstn  input  1  asynchronous, active-low reset.
  pc_write  input  1  1 = PC may advance; 0 = hold (hazard stall).
  ex_valid  input  1  resolve slot valid this cycle.
  ex_is_br  input  1  resolved instruction is a conditional branch.
  ex_is_jmp  input  1  resolved instruction is jal/jalr (always taken).
  ex_taken  input  1  actual branch outcome.
  ex_pc  input  XLEN  PC of the resolved instruction.
  ex_target  input  XLEN  actual taken target (PC+IMM or ALU result).
  ex_pred_taken  input  1  prediction carried down the pipe.
  ex_pred_target  input  XLEN  predicted target carried down the pipe.
  pc  output  XLEN  current fetch PC (register).
  pred_taken  output  1  prediction for pc.
  pred_target  output  XLEN  predicted next PC for pc.
  flush  output  1  mispredict; squash younger instructions.

Function
REQ-005 SHALL index the BTB with pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2]; each entry holds valid, tag, target, 2-bit saturating counter.
REQ-006 SHALL assert pred_taken combinationally when the indexed entry is valid, the tag matches, and counter[1]=1; pred_target = entry target if pred_taken, else pc+4 (modulo 2^XLEN).
REQ-007 SHALL define actual = ex_is_jmp | (ex_is_br & ex_taken); redirect = ex_valid & (ex_is_br|ex_is_jmp) & (actual != ex_pred_taken | (actual & ex_target != ex_pred_target)).
REQ-008 SHALL drive flush = redirect, combinationally, in the same cycle.
REQ-009 SHALL load pc on each edge with priority: redirect -> (actual ? ex_target : ex_pc+4); else pc_write=0 -> pc unchanged; else pred_target.
REQ-010 SHALL have one-cycle redirect latency: corrected pc visible the cycle after flush.
REQ-011 SHALL perform BTB update when ex_valid & (ex_is_br|ex_is_jmp), independent of pc_write.
REQ-012 On update hit: counter +1 saturating at 2'b11 if actual, -1 saturating at 2'b00 if not; target <= ex_target when actual.
REQ-013 On update miss with actual=1: allocate (overwrite) entry: valid=1, tag, target=ex_target, counter=2'b10; ex_is_jmp allocates counter=2'b11.
REQ-014 On update miss with actual=0: no change.
REQ-015 Lookup and update on the same index in the same cycle: lookup SHALL see pre-edge contents.
REQ-016 Non-branch ex_valid (both type bits 0): no update, no redirect.

Reset
REQ-017 rstn=0 SHALL immediately set pc=RESET_PC, clear all valid bits, set all counters to 2'b01; flush follows inputs only.
REQ-018 Reset mid-operation SHALL discard any pending update; first post-reset prediction is pc+4, not taken.

Configuration
REQ-019 Macro NPC_BTB_EN: defined -> BTB and counters as above; undefined -> no BTB storage, pred_taken=0, pred_target=pc+4, every actual-taken branch/jump redirects via REQ-007, REQ-011..015 inert.

Verification
REQ-020 Reset: rstn=0 async with RESET_PC=0x100 -> pc=0x100 without clock edge; pred_taken=0, pred_target=0x104.
REQ-021 Stall: pc=0x200, pc_write=0 for 3 cycles -> pc stays 0x200; pc_write=1 -> 0x204.
REQ-022 Learn loop: branch at 0x40 -> 0x20 resolved taken (pred 0) -> flush=1, next pc=0x20; later fetch of 0x40 -> pred_taken=1, pred_target=0x20.
REQ-023 Saturation: resolve 0x40 not-taken 3 times after allocation -> counter 10->01->00->00, pred_taken=0 after first; mispredict redirects to 0x44.
REQ-024 Priority: redirect with pc_write=0 in same cycle -> pc takes ex_target, stall ignored.
REQ-025 Aliasing (BTB_ENTRIES=16): entries 0x40 and 0x440 share index, differ in tag -> 0x440 lookup misses until allocated, then evicts 0x40.
